kernel_harness_ctrl: RTL
========================

Name: kernel_harness_ctrl

Overview:
- Sequencing controller between the host/test stream and an HLS kernel plus its RAM2 memory.
- Upstream role: preloads kernel input data through RAM2's debug write port while holding the kernel in reset.
- Then releases the kernel's reset and waits for the kernel's valid.
- Downstream role: drains a result window through RAM2's debug read port as a valid/ready stream. This replaces the hand-sequenced preload/run/readback done in kernel benches.

Parameters:
- ADDR_W, 5: RAM2 address width.
- DATA_W, 32: RAM2 data width.
- TIMEOUT, 1024: maximum RUN cycles to wait for kernel valid before aborting. Must be ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- load_valid  in  1  preload beat valid
- load_ready  out  1  preload beat accepted
- load_addr  in  ADDR_W  preload RAM address
- load_data  in  DATA_W  preload RAM data
- start  in  1  level; begin run when sampled high in IDLE
- rd_base  in  ADDR_W  first result address; sampled at start
- rd_count  in  ADDR_W+1  number of result words; sampled at start
- kernel_rst  out  1  drives kernel rst
- kernel_valid  in  1  kernel valid
- mem_wr_addr  out  ADDR_W  to RAM2 debug_write_addr
- mem_wr_data  out  DATA_W  to RAM2 debug_write_data
- mem_wr_en  out  1  to RAM2 debug_write_en
- mem_rd_addr  out  ADDR_W  to RAM2 debug_addr
- mem_rd_data  in  DATA_W  from RAM2 debug_data (combinational read)
- out_valid  out  1  result beat valid
- out_ready  in  1  result beat accepted
- out_data  out  DATA_W  result word
- out_last  out  1  final result beat
- done  out  1  one-cycle pulse at end of run
- error  out  1  qualifies done; 1 = timeout

Behaviour:
- Single clock domain; clk and rst as stated; rst is synchronous, active-high.
- Reset values:
  - state=IDLE, kernel_rst=1.
  - mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, mem_rd_addr=0.
  - out_valid=0, out_last=0, done=0, error=0.
  - Cycle counter and index = 0.
  - load_ready=0 during the rst cycle.
- rst asserted in any state aborts immediately. No done pulse is produced and the kernel is re-held in reset on the next edge.
- States: IDLE, ARM, RUN, DRAIN.
- IDLE:
  - kernel_rst=1; load_ready=1 unless start=1.
  - Accepted beat (load_valid&load_ready): mem_wr_addr/mem_wr_data/mem_wr_en are registered, so the write is presented one cycle after acceptance and mem_wr_en is high exactly that one cycle. Back-to-back beats give back-to-back writes.
  - start=1: load_ready=0 that cycle and no beat is accepted. Latch rd_base/rd_count and go to ARM.
- ARM:
  - Exactly 1 cycle; kernel_rst=1, load_ready=0.
  - Guarantees the last preload write lands in RAM before the kernel leaves reset.
  - Clears the counter, then goes to RUN.
- RUN:
  - kernel_rst=0; counter increments each cycle.
  - kernel_valid=1 → DRAIN with index=0. kernel_valid takes priority over timeout in the same cycle.
  - Counter == TIMEOUT-1 without valid → IDLE, with done=1 and error=1 for one cycle.
- DRAIN:
  - kernel_rst stays 0; the kernel holds its results and valid.
  - mem_rd_addr = (rd_base+index) mod 2^ADDR_W, registered.
  - out_data = mem_rd_data, combinational.
  - out_valid=1 while index < rd_count.
  - out_last = (index == rd_count-1).
  - Handshake: data must stay stable while out_valid&!out_ready; index advances only on out_valid&out_ready.
  - After the last handshake → IDLE; done=1, error=0 for one cycle; kernel_rst=1 again.
  - rd_count=0: DRAIN lasts 1 cycle with out_valid=0, then done/IDLE.
- Address wrap: rd_base+index wraps modulo 2^ADDR_W.
  - Example: rd_base=30, rd_count=4 reads 30, 31, 0, 1.
- start held high after done: a new run begins one cycle after returning to IDLE. Preload is skipped; RAM contents are retained.
- load_valid outside IDLE: ignored, load_ready=0, never written.

Test Plan:
1. Preload (addr 10, data 10), then (addr 11, data 5), back-to-back → mem_wr_en high 2 consecutive cycles with matching addr/data. kernel_rst=1 throughout.
2. start asserted in the same cycle as a load beat → beat not accepted (load_ready=0). ARM lasts 1 cycle, then kernel_rst falls.
3. Stub kernel raises kernel_valid 6 cycles after kernel_rst falls; RAM[0]=7, RAM[1]=9; rd_base=0, rd_count=2, out_ready=1 → beats 7 then 9, out_last on the second beat, done=1/error=0 the next cycle.
4. out_ready toggled 0,1,0,1 during DRAIN with rd_base=30, rd_count=4 → addresses 30, 31, 0, 1 in order. out_data is stable during stalls. Exactly 4 handshakes occur.
5. TIMEOUT=16, kernel_valid never asserted → done=1 and error=1 exactly 16 cycles after RUN entry; kernel_rst=1 next cycle.
6. rst pulsed mid-DRAIN → next cycle state IDLE, kernel_rst=1, out_valid=0, no done pulse. rd_count=0 run → done with zero out beats.

Source files
------------

// File: rtl/kernel_harness_ctrl.sv
// rtl/kernel_harness_ctrl.sv - preload / run / drain sequencer for an HLS kernel and its RAM2
// Holds the kernel in reset while the host preloads RAM2, runs it until valid or timeout, then streams a result window.
module kernel_harness_ctrl #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_count,
  output logic              kernel_rst,
  input  logic              kernel_valid,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      base_q    <= '0;
      count_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      base_q    <= base_d;
      count_q   <= count_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    base_d     = base_q;
    count_d    = count_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    load_ready = 1'b0;
    kernel_rst = 1'b1;
    out_valid  = 1'b0;
    out_last   = 1'b0;

    case (state_q)
      IDLE: begin
        load_ready = !start && !rst;
        if (start) begin
          base_d  = rd_base;
          count_d = rd_count;
          state_d = ARM;
        end else if (load_valid && load_ready) begin
          wr_en_d   = 1'b1;
          wr_addr_d = load_addr;
          wr_data_d = load_data;
        end
      end
      ARM: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        kernel_rst = 1'b0;
        cnt_d      = cnt_q + CNT_W'(1);
        if (kernel_valid) begin
          idx_d   = '0;
          state_d = DRAIN;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        kernel_rst = 1'b0;
        out_valid  = idx_q < count_q;
        out_last   = out_valid && (idx_q == count_q - (ADDR_W+1)'(1));
        if (!out_valid || (out_ready && out_last)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (out_ready) begin
          idx_d = idx_q + (ADDR_W+1)'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Read address is registered, so it tracks the index the next cycle will present.
    if (state_q == RUN || state_q == DRAIN) begin
      rd_addr_d = base_q + idx_d[ADDR_W-1:0];
    end
  end

  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign out_data    = mem_rd_data;
  assign done        = done_q;
  assign error       = error_q;

endmodule
